// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes (also used by the ALU control decoder) and
// execute-stage FSM states.
package alu_pkg;

    localparam int unsigned AluCtrlW = 4;

    typedef enum logic [AluCtrlW-1:0] {
        AluOr  = 4'b0000,
        AluAnd = 4'b0001,
        AluAdd = 4'b0010,
        AluXor = 4'b0100,
        AluSub = 4'b0110,
        AluSlt = 4'b0111,
        AluMul = 4'b1111
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StHold
    } alu_state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles after start.
// o_done and o_product are valid in the cycle whose edge performs the last iteration.
module alu_mul_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_product
);
    localparam int unsigned CntW = $clog2(WIDTH);

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CntW-1:0]  r_cnt;
    logic             r_busy;
    logic [WIDTH-1:0] w_acc_next;

    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign o_done     = r_busy && (r_cnt == CntW'(WIDTH - 1));
    assign o_product  = w_acc_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (i_start) begin
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CntW'(1);
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU with valid/ready handshake and registered result/flags.
// Define ALU_EXEC_MUL_EN to build in the iterative multiplier for code 1111.
module alu_exec
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [AluCtrlW-1:0] alu_control,
    input  logic [WIDTH-1:0]    operand_a,
    input  logic [WIDTH-1:0]    operand_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    result,
    output logic                zero,
    output logic                overflow,
    output logic                illegal
);
    alu_state_t       r_state;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_overflow;
    logic             r_illegal;

    logic             w_accept;
    logic             w_is_mul;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_result;
    logic             w_overflow;
    logic             w_illegal;

    assign in_ready  = (r_state == StIdle) || ((r_state == StHold) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign overflow  = r_overflow;
    assign illegal   = r_illegal;

    assign w_sum  = operand_a + operand_b;
    assign w_diff = operand_a - operand_b;

    always_comb begin
        w_result   = '0;
        w_overflow = 1'b0;
        w_illegal  = 1'b0;
        case (alu_control)
            AluOr:  w_result = operand_a | operand_b;
            AluAnd: w_result = operand_a & operand_b;
            AluXor: w_result = operand_a ^ operand_b;
            AluAdd: begin
                w_result   = w_sum;
                w_overflow = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                             (w_sum[WIDTH-1] != operand_a[WIDTH-1]);
            end
            AluSub: begin
                w_result   = w_diff;
                w_overflow = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                             (w_diff[WIDTH-1] != operand_a[WIDTH-1]);
            end
            // True signed compare; the wrapped difference's sign is wrong on overflow.
            AluSlt: w_result = {{(WIDTH-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
            default: w_illegal = 1'b1;
        endcase
    end

`ifdef ALU_EXEC_MUL_EN
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_product;

    assign w_is_mul = (alu_control == AluMul);

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_accept && w_is_mul),
        .i_a       (operand_a),
        .i_b       (operand_b),
        .o_done    (w_mul_done),
        .o_product (w_mul_product)
    );
`else
    assign w_is_mul = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_overflow  <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            case (r_state)
                StIdle, StHold: begin
                    if (w_accept && w_is_mul) begin
                        r_state     <= StMul;
                        r_out_valid <= 1'b0;
                    end else if (w_accept) begin
                        r_state     <= StHold;
                        r_out_valid <= 1'b1;
                        r_result    <= w_result;
                        r_zero      <= (w_result == '0);
                        r_overflow  <= w_overflow;
                        r_illegal   <= w_illegal;
                    end else if ((r_state == StHold) && out_ready) begin
                        r_state     <= StIdle;
                        r_out_valid <= 1'b0;
                    end
                end
`ifdef ALU_EXEC_MUL_EN
                StMul: begin
                    if (w_mul_done) begin
                        r_state     <= StHold;
                        r_out_valid <= 1'b1;
                        r_result    <= w_mul_product;
                        r_zero      <= (w_mul_product == '0);
                        r_overflow  <= 1'b0;
                        r_illegal   <= 1'b0;
                    end
                end
`endif
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/alu_exec.md
# alu_exec

Execute-stage ALU for the processor datapath, directly downstream of the ALU control decoder. It consumes the 4-bit ALU control code plus two operands, and produces a registered result with zero and overflow flags. It uses a valid/ready handshake on both sides. Logic ops, ADD, SUB and SLT complete in one cycle; the multiply code (4'b1111) runs an iterative shift-add multiply and back-pressures the front end until it finishes.

## Interface
- WIDTH, 32, operand/result width in bits (≥ 2)
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- in_valid  in  1  operation presented this cycle
- in_ready  out  1  block accepts an operation this cycle
- alu_control  in  4  operation code from ALU control decoder
- operand_a  in  WIDTH  first operand (minuend for SUB, left side for SLT)
- operand_b  in  WIDTH  second operand
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer accepts result this cycle
- result  out  WIDTH  registered result
- zero  out  1  result == 0
- overflow  out  1  signed overflow (ADD/SUB only, else 0)
- illegal  out  1  alu_control was not a supported code

## Operation
- Codes: 0000 OR; 0001 AND; 0010 ADD; 0100 XOR; 0110 SUB (a−b); 0111 SLT (signed a<b → 1, else 0); 1111 MUL (low WIDTH bits of a×b, unsigned/two's-complement identical).
- Any other code: result 0, zero 1, overflow 0, illegal 1. Single-cycle.
- ADD/SUB wrap modulo 2^WIDTH. Overflow is set when the operands have equal signs (ADD) or different signs (SUB) and the result sign differs from a.
- SLT uses the true signed comparison, not the sign of the wrapped difference.
- Accept = in_valid && in_ready. Operands and code are captured only on accept.
- FSM states: IDLE, MUL, HOLD.
  - IDLE: accepting a non-MUL op loads the output registers and goes to HOLD. Accepting MUL loads the multiplicand, multiplier and accumulator, clears the counter and goes to MUL.
  - MUL: each cycle, add the multiplicand to the accumulator if multiplier bit0 is set, shift the multiplicand left and the multiplier right, and increment the counter. After the WIDTH-th iteration, load the output registers and go to HOLD.
  - HOLD: out_valid=1. On out_ready, go to IDLE, or directly accept the next op when in_valid is high (pipelined back-to-back).
- in_ready = (state==IDLE) || (state==HOLD && out_ready).
- Operand changes while in MUL or HOLD are ignored.
- Reset: state IDLE; out_valid 0; result 0; zero 0; overflow 0; illegal 0; counter 0; in_ready 1 in the first cycle after reset. A reset during MUL or HOLD discards the in-flight op with no output.

## Timing
- Single-cycle op accepted at edge N: out_valid=1 from edge N through the edge at which out_ready is seen.
- MUL accepted at edge N: out_valid=1 after edge N+WIDTH (latency WIDTH+1 cycles including accept). in_ready=0 for the WIDTH cycles in MUL.
- Back-to-back throughput: one single-cycle op per clock while out_ready is held at 1.
- Outputs are fully registered; there is no combinational path from the operands to result.
- in_ready depends combinationally on out_ready only.

## Configuration
- ALU_EXEC_MUL_EN defined: MUL state and iterative multiplier are compiled in, and code 1111 behaves as described above.
- ALU_EXEC_MUL_EN undefined: MUL state and datapath are absent. Code 1111 is treated as illegal (result 0, illegal 1, single-cycle).

## Structure
- Shared package alu_pkg holds:
  - alu_ctrl_t enum (OR, AND, ADD, XOR, SUB, SLT, MUL code values), reused by the ALU control decoder
  - alu_state_t enum (IDLE, MUL, HOLD)
- One sub-module: alu_mul_iter (multiplicand/multiplier/accumulator/counter, with start and done signals), instantiated only under ALU_EXEC_MUL_EN.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 → result 0x80000000, overflow 1, zero 0, out_valid one cycle after accept.
- SUB 5 − 5 → result 0, zero 1. SLT 0xFFFFFFFF vs 0x00000001 → result 1 (signed).
- Back-to-back with out_ready=1: OR 0xF0F0F0F0|0x0F0F0F0F, then AND, then XOR on consecutive clocks → results 0xFFFFFFFF, 0x00000000, 0xFFFFFFFF on three consecutive cycles.
- MUL 0x00012345 × 0x00000100 (MUL_EN) → 0x01234500 valid exactly 32 cycles after the accept edge; in_ready 0 throughout. Without MUL_EN → illegal 1, result 0.
- Backpressure: out_ready=0 for 5 cycles in HOLD → result stable, in_ready 0, and a new op is accepted on the cycle out_ready rises.
- Reset asserted mid-MUL (cycle 10) → out_valid stays 0 and next accept behaves normally. Code 0011 → illegal 1, result 0, zero 1.
